enemy_dir_ctrl: RTL and testbench



---
 rtl/enemy_pkg.sv | 53 +++++
 rtl/lfsr16.sv | 31 +++
 rtl/enemy_dir_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_enemy_dir_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_pkg.sv
`default_nettype none
// ============================================================================
// Package  : enemy_pkg
// Brief    : Shared types and helpers for the per-enemy movement controller:
//            direction codes, enemy type codes, controller states and the
//            direction-reversal helper.
// Revision : 1.0 - initial release
// ============================================================================
package enemy_pkg;

  // Direction command understood by the Enemy block
  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_LEFT  = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_DOWN  = 3'd3,
    DIR_UP    = 3'd4
  } dir_t;

  // Enemy type codes reported by the Enemy block
  localparam logic [1:0] TYPE_NONE   = 2'd0;
  localparam logic [1:0] TYPE_KEESE  = 2'd1;
  localparam logic [1:0] TYPE_REDEAD = 2'd2;
  localparam logic [1:0] TYPE_SLIDER = 2'd3;

  // Parking coordinate used by the Enemy block while inactive
  localparam logic [9:0] c_park_pos = 10'd700;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_WANDER  = 3'd2,
    ST_CHASE   = 3'd3,
    ST_SLIDE   = 3'd4,
    ST_BACKOFF = 3'd5
  } ctrl_state_t;

  // Reverse a direction along its own axis; DIR_NONE maps to itself
  function automatic dir_t opposite_dir(input dir_t d);
    dir_t r;
    case (d)
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      DIR_DOWN:  r = DIR_UP;
      DIR_UP:    r = DIR_DOWN;
      default:   r = DIR_NONE;
    endcase
    return r;
  endfunction

endpackage : enemy_pkg
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Brief    : 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in the
//            right-shifting form). Advances one step per enable.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        en,
  output logic [15:0] q
);

  logic w_fb;

  assign w_fb = q[0] ^ q[2] ^ q[3] ^ q[5];

  // Shift right, feeding the tap XOR into the MSB; reload the seed on reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q <= SEED;
    end else if (en) begin
      q <= {w_fb, q[15:1]};
    end
  end

endmodule : lfsr16
`default_nettype wire

// File: rtl/enemy_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : enemy_dir_ctrl
// Brief    : Per-enemy movement controller. Sequences room-entry spawn,
//            picks a direction once per frame by enemy type (wander, chase,
//            slide) and backs off / reverses when position feedback shows the
//            enemy is stuck against a wall.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_dir_ctrl
  import enemy_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES  = 32,
  parameter int unsigned CHASE_RADIUS = 128,
  parameter int unsigned STALL_FRAMES = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       room_change,
  input  logic [9:0] Enemy_X,
  input  logic [9:0] Enemy_Y,
  input  logic       active,
  input  logic [1:0] Enemy_Type,
  input  logic [9:0] Player_X,
  input  logic [9:0] Player_Y,
  output logic [2:0] dir,
  output logic       initialize
);

  // Counter widths and reload values
  localparam int c_hold_w  = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
  localparam int c_stall_w = (STALL_FRAMES > 1) ? $clog2(STALL_FRAMES + 1) : 1;

  localparam logic [c_hold_w-1:0]  c_hold_reload    = c_hold_w'(HOLD_FRAMES - 1);
  localparam logic [c_hold_w-1:0]  c_backoff_reload = c_hold_w'(HOLD_FRAMES / 2 - 1);
  localparam logic [c_hold_w-1:0]  c_hold_one       = c_hold_w'(1);
  localparam logic [c_stall_w-1:0] c_stall_one      = c_stall_w'(1);
  localparam logic [c_stall_w-1:0] c_stall_limit    = c_stall_w'(STALL_FRAMES);
  localparam logic [11:0]          c_radius         = 12'(CHASE_RADIUS);

  // Registered state
  logic                 r_frame_q;
  ctrl_state_t          r_state;
  dir_t                 r_dir;
  logic                 r_init;
  logic [c_hold_w-1:0]  r_hold;
  logic [c_stall_w-1:0] r_stall;
  logic                 r_skip;
  logic [9:0]           r_prev_x;
  logic [9:0]           r_prev_y;

  // Combinational helpers
  logic                 w_fe;
  logic [15:0]          w_lfsr;
  ctrl_state_t          w_type_state;
  dir_t                 w_roll_dir;
  dir_t                 w_chase_dir;
  dir_t                 w_entry_dir;
  logic signed [10:0]   w_dx;
  logic signed [10:0]   w_dy;
  logic [10:0]          w_adx;
  logic [10:0]          w_ady;
  logic [11:0]          w_dist;
  logic                 w_parked;
  logic                 w_blocked;
  logic                 w_stall_eval;
  logic [c_stall_w-1:0] w_stall_inc;
  logic [c_stall_w-1:0] w_stall_next;
  logic                 w_stall_hit;

  assign dir        = r_dir;
  assign initialize = r_init;

  // Same rising-edge detector as the Enemy block so both act in one Clk cycle
  always_ff @(posedge Clk) begin
    r_frame_q <= frame_clk;
  end

  assign w_fe = frame_clk & ~r_frame_q;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (w_fe),
    .q     (w_lfsr)
  );

  // Map the reported enemy type to the state that handles it
  always_comb begin
    w_type_state = ST_IDLE;
    case (Enemy_Type)
      TYPE_KEESE:  w_type_state = ST_WANDER;
      TYPE_REDEAD: w_type_state = ST_CHASE;
      TYPE_SLIDER: w_type_state = ST_SLIDE;
      default:     w_type_state = ST_IDLE;
    endcase
  end

  // Random wander direction is always one of the four real directions
  assign w_roll_dir = dir_t'({1'b0, w_lfsr[1:0]} + 3'd1);

  // Player offset as 11-bit signed values; magnitudes summed at 12 bits
  assign w_dx   = $signed({1'b0, Player_X}) - $signed({1'b0, Enemy_X});
  assign w_dy   = $signed({1'b0, Player_Y}) - $signed({1'b0, Enemy_Y});
  assign w_adx  = w_dx[10] ? $unsigned(-w_dx) : $unsigned(w_dx);
  assign w_ady  = w_dy[10] ? $unsigned(-w_dy) : $unsigned(w_dy);
  assign w_dist = {1'b0, w_adx} + {1'b0, w_ady};

  // Chase toward the player along the dominant axis; X wins ties
  always_comb begin
    w_chase_dir = DIR_NONE;
    if ((w_dist >= c_radius) || (w_dist == 12'd0)) begin
      w_chase_dir = DIR_NONE;
    end else if (w_adx >= w_ady) begin
      w_chase_dir = w_dx[10] ? DIR_LEFT : DIR_RIGHT;
    end else begin
      w_chase_dir = w_dy[10] ? DIR_UP : DIR_DOWN;
    end
  end

  // First direction issued when a type state is entered
  always_comb begin
    w_entry_dir = DIR_NONE;
    case (w_type_state)
      ST_WANDER: w_entry_dir = w_roll_dir;
      ST_CHASE:  w_entry_dir = w_chase_dir;
      ST_SLIDE:  w_entry_dir = DIR_RIGHT;
      default:   w_entry_dir = DIR_NONE;
    endcase
  end

  // Parked coordinates carry no motion information
  assign w_parked = ((Enemy_X == c_park_pos) && (Enemy_Y == c_park_pos)) ||
                    ((r_prev_x == c_park_pos) && (r_prev_y == c_park_pos));

  // A frame is blocked when the commanded axis failed to move the right way
  always_comb begin
    w_blocked = 1'b0;
    case (r_dir)
      DIR_LEFT:  w_blocked = (Enemy_X >= r_prev_x);
      DIR_RIGHT: w_blocked = (Enemy_X <= r_prev_x);
      DIR_DOWN:  w_blocked = (Enemy_Y <= r_prev_y);
      DIR_UP:    w_blocked = (Enemy_Y >= r_prev_y);
      default:   w_blocked = 1'b0;
    endcase
  end

  // Stall bookkeeping skips the frame right after a direction change
  assign w_stall_eval = ((r_state == ST_WANDER) || (r_state == ST_CHASE) ||
                         (r_state == ST_SLIDE)) &&
                        (r_dir != DIR_NONE) && !r_skip && !w_parked;
  assign w_stall_inc  = r_stall + c_stall_one;
  assign w_stall_next = w_stall_eval ? (w_blocked ? w_stall_inc : '0) : r_stall;
  assign w_stall_hit  = w_stall_eval && w_blocked && (w_stall_inc == c_stall_limit);

  // Controller FSM: spawn sequencing, per-type direction choice and backoff
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_dir    <= DIR_NONE;
      r_init   <= 1'b0;
      r_hold   <= '0;
      r_stall  <= '0;
      r_skip   <= 1'b0;
      r_prev_x <= '0;
      r_prev_y <= '0;
    end else if (room_change) begin
      r_state <= ST_INIT;
      r_dir   <= DIR_NONE;
      r_init  <= 1'b1;
      r_hold  <= '0;
      r_stall <= '0;
      r_skip  <= 1'b0;
      if (w_fe) begin
        r_prev_x <= Enemy_X;
        r_prev_y <= Enemy_Y;
      end
    end else if (w_fe) begin
      r_prev_x <= Enemy_X;
      r_prev_y <= Enemy_Y;
      case (r_state)
        ST_INIT: begin
          // Spawn strobe has now covered exactly one frame edge
          r_init  <= 1'b0;
          r_state <= ST_IDLE;
        end

        ST_BACKOFF: begin
          r_skip <= 1'b0;
          if (!active) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_NONE;
            r_hold  <= '0;
            r_stall <= '0;
          end else if (r_hold == '0) begin
            r_state <= w_type_state;
            r_stall <= '0;
            if (w_type_state == ST_IDLE) begin
              r_dir <= DIR_NONE;
            end
          end else begin
            r_hold <= r_hold - c_hold_one;
          end
        end

        default: begin
          if (!active || (w_type_state == ST_IDLE)) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_NONE;
            r_hold  <= '0;
            r_stall <= '0;
            r_skip  <= 1'b0;
          end else if (w_type_state != r_state) begin
            // Dispatch (from IDLE) or re-dispatch after a type change
            r_state <= w_type_state;
            r_dir   <= w_entry_dir;
            r_hold  <= (w_type_state == ST_WANDER) ? c_hold_reload : '0;
            r_stall <= '0;
            r_skip  <= (w_entry_dir != r_dir);
          end else if (w_stall_hit && (r_state == ST_SLIDE)) begin
            r_dir   <= opposite_dir(r_dir);
            r_stall <= '0;
            r_skip  <= 1'b1;
          end else if (w_stall_hit) begin
            r_state <= ST_BACKOFF;
            r_dir   <= opposite_dir(r_dir);
            r_hold  <= c_backoff_reload;
            r_stall <= '0;
            r_skip  <= 1'b1;
          end else if (r_state == ST_WANDER) begin
            if (r_hold == '0) begin
              r_dir   <= w_roll_dir;
              r_hold  <= c_hold_reload;
              r_stall <= (w_roll_dir != r_dir) ? '0 : w_stall_next;
              r_skip  <= (w_roll_dir != r_dir);
            end else begin
              r_hold  <= r_hold - c_hold_one;
              r_stall <= w_stall_next;
              r_skip  <= 1'b0;
            end
          end else if (r_state == ST_CHASE) begin
            r_dir   <= w_chase_dir;
            r_stall <= (w_chase_dir != r_dir) ? '0 : w_stall_next;
            r_skip  <= (w_chase_dir != r_dir);
          end else begin
            // Slider simply holds its direction
            r_stall <= w_stall_next;
            r_skip  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule : enemy_dir_ctrl
`default_nettype wire

// File: tb/tb_enemy_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_dir_ctrl
// Brief    : Self-checking bench for enemy_dir_ctrl. Expected directions come
//            from a distance/sign model of the chase rule and an arithmetic
//            model of the LFSR sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_dir_ctrl;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       room_change = 1'b0;
  logic [9:0] Enemy_X = 10'd300;
  logic [9:0] Enemy_Y = 10'd200;
  logic       active = 1'b0;
  logic [1:0] Enemy_Type = 2'd0;
  logic [9:0] Player_X = 10'd0;
  logic [9:0] Player_Y = 10'd0;
  logic [2:0] dir;
  logic       initialize;

  int checks = 0;
  int errors = 0;

  enemy_dir_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .room_change (room_change),
    .Enemy_X     (Enemy_X),
    .Enemy_Y     (Enemy_Y),
    .active      (active),
    .Enemy_Type  (Enemy_Type),
    .Player_X    (Player_X),
    .Player_Y    (Player_Y),
    .dir         (dir),
    .initialize  (initialize)
  );

  // 10-unit clock
  always #5 Clk = ~Clk;

  // Frame clock: 20 Clk period, 10 high / 10 low, changed on the falling edge
  int fcnt = 0;
  always @(negedge Clk) begin
    fcnt      <= (fcnt == 19) ? 0 : fcnt + 1;
    frame_clk <= (fcnt == 19) || (fcnt < 9);
  end

  // Golden LFSR as plain shift/XOR arithmetic
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] b;
    b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'd1;
    return (s >> 1) | (b << 15);
  endfunction

  // Frame-edge tracking and LFSR reference (value seen at the latest edge)
  logic        fq = 1'b0;
  int          fe_cnt = 0;
  logic [15:0] m_lfsr = SEED;
  logic [15:0] m_lfsr_at_fe = SEED;
  always @(posedge Clk) begin
    fq <= frame_clk;
    if (frame_clk && !fq) fe_cnt <= fe_cnt + 1;
    if (Reset) begin
      m_lfsr <= SEED;
    end else if (frame_clk && !fq) begin
      m_lfsr_at_fe <= m_lfsr;
      m_lfsr       <= lfsr_step(m_lfsr);
    end
  end

  // Chase rule: Manhattan distance gate, dominant axis, X on ties
  function automatic int chase_ref(int ex, int ey, int px, int py);
    int dx, dy, ax, ay;
    dx = px - ex;
    dy = py - ey;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    if (ax + ay >= 128 || ax + ay == 0) return 0;
    if (ax >= ay) return (dx < 0) ? 1 : 2;
    return (dy < 0) ? 4 : 3;
  endfunction

  // Wait for the next frame edge; returns on the falling Clk edge after it
  task automatic wait_fe();
    int start;
    int n;
    start = fe_cnt;
    n = 0;
    while (fe_cnt == start && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (fe_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL wait_fe: no frame edge within %0d cycles", n);
    end
  endtask

  // Pulse room_change just after a frame edge, then let INIT consume one edge
  task automatic enter_room();
    wait_fe();
    room_change = 1'b1;
    @(negedge Clk);
    room_change = 1'b0;
    wait_fe();
  endtask

  // Move the enemy one pixel in the commanded direction
  task automatic move_enemy();
    case (dir)
      3'd1: Enemy_X = Enemy_X - 10'd1;
      3'd2: Enemy_X = Enemy_X + 10'd1;
      3'd3: Enemy_Y = Enemy_Y + 10'd1;
      3'd4: Enemy_Y = Enemy_Y - 10'd1;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    checks++;
    if (dir !== 3'd0 || initialize !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: dir=%0d init=%0b, required dir=0 init=0", dir, initialize);
    end
    Reset = 1'b0;
    @(negedge Clk);
    checks++;
    if (dir !== 3'd0 || initialize !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: dir=%0d init=%0b, required dir=0 init=0", dir, initialize);
    end
  endtask

  // Check initialize stays high until a frame edge, then drops one Clk later
  task automatic check_init_window(input string name);
    int start;
    int n;
    int bad;
    start = fe_cnt;
    n = 0;
    bad = 0;
    while (fe_cnt == start && n < 40) begin
      if (initialize !== 1'b1 || dir !== 3'd0) bad++;
      @(negedge Clk);
      n++;
    end
    checks++;
    if (bad != 0 || fe_cnt == start) begin
      errors++;
      $display("FAIL %s_hold: %0d cycles with init low or dir nonzero (edge seen=%0b), required 0",
               name, bad, fe_cnt != start);
    end
    checks++;
    if (initialize !== 1'b0) begin
      errors++;
      $display("FAIL %s_drop: init=%0b one Clk after edge, required 0", name, initialize);
    end
  endtask

  task automatic test_room_change_init();
    active = 1'b0;
    Enemy_Type = 2'd0;
    wait_fe();
    repeat (2) @(negedge Clk);
    room_change = 1'b1;
    @(negedge Clk);
    room_change = 1'b0;
    checks++;
    if (initialize !== 1'b1) begin
      errors++;
      $display("FAIL init_rise: init=%0b, required 1", initialize);
    end
    check_init_window("init");
    wait_fe();
    checks++;
    if (initialize !== 1'b0 || dir !== 3'd0) begin
      errors++;
      $display("FAIL init_after: dir=%0d init=%0b, required 0/0", dir, initialize);
    end
  endtask

  task automatic test_chase_fixed();
    int exp;
    active = 1'b1;
    Enemy_Type = 2'd2;
    enter_room();
    Enemy_X = 10'd300; Enemy_Y = 10'd200;
    Player_X = 10'd350; Player_Y = 10'd210;
    wait_fe();
    exp = chase_ref(300, 200, 350, 210);
    checks++;
    if (dir !== 3'(exp)) begin
      errors++;
      $display("FAIL chase_right: dir=%0d, required %0d", dir, exp);
    end
    Player_X = 10'd300; Player_Y = 10'd100;
    wait_fe();
    exp = chase_ref(300, 200, 300, 100);
    checks++;
    if (dir !== 3'(exp)) begin
      errors++;
      $display("FAIL chase_up: dir=%0d, required %0d", dir, exp);
    end
    Player_X = 10'd500; Player_Y = 10'd400;
    wait_fe();
    exp = chase_ref(300, 200, 500, 400);
    checks++;
    if (dir !== 3'(exp)) begin
      errors++;
      $display("FAIL chase_far: dir=%0d, required %0d", dir, exp);
    end
  endtask

  task automatic test_chase_random();
    int ex, ey, px, py, a, b, sx, sy, exp;
    active = 1'b1;
    Enemy_Type = 2'd2;
    for (int i = 0; i < 16; i++) begin
      enter_room();
      ex = $urandom_range(200, 800);
      ey = $urandom_range(200, 800);
      sx = ($urandom_range(0, 1) != 0) ? 1 : -1;
      sy = ($urandom_range(0, 1) != 0) ? 1 : -1;
      case (i % 4)
        0: begin a = $urandom_range(0, 100); b = $urandom_range(0, 100); end
        1: begin a = $urandom_range(1, 63);  b = a; end
        2: begin a = $urandom_range(64, 180); b = $urandom_range(0, 180); end
        default: begin a = $urandom_range(0, 127); b = 127 - a + (i % 8 == 7 ? 1 : 0); end
      endcase
      px = ex + sx * a;
      py = ey + sy * b;
      Enemy_X = 10'(ex); Enemy_Y = 10'(ey);
      Player_X = 10'(px); Player_Y = 10'(py);
      wait_fe();
      exp = chase_ref(ex, ey, px, py);
      checks++;
      if (dir !== 3'(exp)) begin
        errors++;
        $display("FAIL chase_rand[%0d]: E(%0d,%0d) P(%0d,%0d) dir=%0d, required %0d",
                 i, ex, ey, px, py, dir, exp);
      end
    end
  endtask

  task automatic test_slide();
    active = 1'b1;
    Enemy_Type = 2'd3;
    Enemy_X = 10'd400; Enemy_Y = 10'd200;
    enter_room();
    wait_fe();
    checks++;
    if (dir !== 3'd2) begin
      errors++;
      $display("FAIL slide_start: dir=%0d, required 2", dir);
    end
    // Lag frame plus two blocked frames keep the direction
    for (int k = 0; k < 3; k++) begin
      wait_fe();
      checks++;
      if (dir !== 3'd2) begin
        errors++;
        $display("FAIL slide_hold[%0d]: dir=%0d, required 2", k, dir);
      end
    end
    wait_fe();
    checks++;
    if (dir !== 3'd1) begin
      errors++;
      $display("FAIL slide_reverse: dir=%0d, required 1", dir);
    end
    for (int k = 0; k < 5; k++) begin
      Enemy_X = Enemy_X - 10'd1;
      wait_fe();
      checks++;
      if (dir !== 3'd1) begin
        errors++;
        $display("FAIL slide_keep[%0d]: dir=%0d, required 1", k, dir);
      end
    end
  endtask

  task automatic test_wander();
    logic [2:0] exp;
    active = 1'b1;
    Enemy_Type = 2'd1;
    Enemy_X = 10'd300; Enemy_Y = 10'd200;
    enter_room();
    exp = 3'd0;
    for (int f = 0; f < 70; f++) begin
      wait_fe();
      if (f % 32 == 0) exp = {1'b0, m_lfsr_at_fe[1:0]} + 3'd1;
      checks++;
      if (dir !== exp || dir == 3'd0 || dir > 3'd4) begin
        errors++;
        $display("FAIL wander[%0d]: dir=%0d, required %0d", f, dir, exp);
      end
      move_enemy();
    end
  endtask

  task automatic test_active_drop_and_rc_on_fe();
    int n;
    active = 1'b1;
    Enemy_Type = 2'd2;
    enter_room();
    Enemy_X = 10'd300; Enemy_Y = 10'd200;
    Player_X = 10'd350; Player_Y = 10'd210;
    wait_fe();
    checks++;
    if (dir !== 3'd2) begin
      errors++;
      $display("FAIL drop_pre: dir=%0d, required 2", dir);
    end
    active = 1'b0;
    wait_fe();
    checks++;
    if (dir !== 3'd0) begin
      errors++;
      $display("FAIL active_drop: dir=%0d, required 0", dir);
    end
    // Raise room_change in the very cycle whose rising edge sees fe
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (fcnt != 19 && n < 40);
    room_change = 1'b1;
    @(negedge Clk);
    room_change = 1'b0;
    checks++;
    if (initialize !== 1'b1) begin
      errors++;
      $display("FAIL rc_on_fe_rise: init=%0b, required 1", initialize);
    end
    check_init_window("rc_on_fe");
  endtask

  task automatic test_backoff_reset();
    active = 1'b1;
    Enemy_Type = 2'd2;
    enter_room();
    Enemy_X = 10'd300; Enemy_Y = 10'd200;
    Player_X = 10'd350; Player_Y = 10'd210;
    // Entry edge, lag edge and two blocked edges keep heading right
    for (int k = 0; k < 4; k++) begin
      wait_fe();
      checks++;
      if (dir !== 3'd2) begin
        errors++;
        $display("FAIL stall_pre[%0d]: dir=%0d, required 2", k, dir);
      end
    end
    wait_fe();
    checks++;
    if (dir !== 3'd1) begin
      errors++;
      $display("FAIL backoff_dir: dir=%0d, required 1", dir);
    end
    repeat (2) wait_fe();
    checks++;
    if (dir !== 3'd1) begin
      errors++;
      $display("FAIL backoff_hold: dir=%0d, required 1", dir);
    end
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (dir !== 3'd0 || initialize !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_backoff: dir=%0d init=%0b, required 0/0", dir, initialize);
    end
    Reset = 1'b0;
    Enemy_Type = 2'd1;
    wait_fe();
    checks++;
    if (dir !== ({1'b0, m_lfsr_at_fe[1:0]} + 3'd1)) begin
      errors++;
      $display("FAIL lfsr_reload: dir=%0d, required %0d", dir, {1'b0, m_lfsr_at_fe[1:0]} + 3'd1);
    end
  endtask

  initial begin
    test_reset();
    test_room_change_init();
    test_chase_fixed();
    test_chase_random();
    test_slide();
    test_wander();
    test_active_drop_and_rc_on_fe();
    test_backoff_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_enemy_dir_ctrl
`default_nettype wire
